// File: rtl/ahb3lite_gpio_timer.sv
// AHB3-Lite responder exposing LED outputs, synchronized buttons and a 32-bit down-counter with IRQ.
// Legal word accesses complete with zero wait states; illegal ones receive a two-cycle ERROR.
module ahb3lite_gpio_timer #(
  parameter int g_haddr_size = 32,
  parameter int g_hdata_size = 32,
  parameter int g_gpo_width  = 8,
  parameter int g_gpi_width  = 1
) (
  input  logic                    hclk_i,
  input  logic                    hreset_n_i,
  input  logic                    hsel_i,
  input  logic [g_haddr_size-1:0] haddr_i,
  input  logic [g_hdata_size-1:0] hwdata_i,
  output logic [g_hdata_size-1:0] hrdata_o,
  input  logic                    hwrite_i,
  input  logic [2:0]              hsize_i,
  input  logic [2:0]              hburst_i,
  input  logic [3:0]              hprot_i,
  input  logic [1:0]              htrans_i,
  output logic                    hreadyout_o,
  input  logic                    hready_i,
  output logic                    hresp_o,
  output logic [g_gpo_width-1:0]  gpo_o,
  input  logic [g_gpi_width-1:0]  gpi_i,
  output logic                    irq_o
);

  localparam logic [2:0] a_gpo    = 3'd0;
  localparam logic [2:0] a_gpi    = 3'd1;
  localparam logic [2:0] a_ctrl   = 3'd2;
  localparam logic [2:0] a_load   = 3'd3;
  localparam logic [2:0] a_count  = 3'd4;
  localparam logic [2:0] a_status = 3'd5;
  localparam logic [g_hdata_size-1:0] count_one = {{(g_hdata_size-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {st_idle, st_err1, st_err2} state_t;

  state_t                  state_reg, state_next;
  logic                    valid, legal;
  logic                    dp_valid_reg, dp_write_reg;
  logic [2:0]              dp_addr_reg;
  logic [g_gpo_width-1:0]  gpo_reg, gpo_next;
  logic [g_gpi_width-1:0]  gpi_meta_reg, gpi_sync_reg;
  logic                    enable_reg, enable_next;
  logic                    auto_reg, auto_next;
  logic                    irq_en_reg, irq_en_next;
  logic                    expired_reg, expired_next;
  logic [g_hdata_size-1:0] load_reg, load_next;
  logic [g_hdata_size-1:0] count_reg, count_next;
  logic                    expire;
  logic                    wr, wr_gpo, wr_ctrl, wr_load, wr_status;
  logic                    unused_bits;

  assign unused_bits = ^{hburst_i, hprot_i, htrans_i[0], haddr_i[g_haddr_size-1:5], haddr_i[1:0]};

  assign valid = hsel_i & hready_i & htrans_i[1];
  assign legal = (hsize_i == 3'b010) && (haddr_i[4:2] <= a_status);

  // Illegal transfers never reach the data-phase register, so they cannot cause side effects.
  always_ff @(posedge hclk_i or negedge hreset_n_i) begin
    if (!hreset_n_i) begin
      dp_valid_reg <= 1'b0;
      dp_write_reg <= 1'b0;
      dp_addr_reg  <= 3'd0;
    end else begin
      dp_valid_reg <= valid & legal;
      if (valid) begin
        dp_write_reg <= hwrite_i;
        dp_addr_reg  <= haddr_i[4:2];
      end
    end
  end

  always_ff @(posedge hclk_i or negedge hreset_n_i) begin
    if (!hreset_n_i) state_reg <= st_idle;
    else             state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      st_idle: if (valid && !legal) state_next = st_err1;
      st_err1: state_next = st_err2;
      st_err2: state_next = (valid && !legal) ? st_err1 : st_idle;
      default: state_next = st_idle;
    endcase
  end

  assign hreadyout_o = (state_reg != st_err1);
  assign hresp_o     = (state_reg != st_idle);

  assign wr        = dp_valid_reg & dp_write_reg;
  assign wr_gpo    = wr && (dp_addr_reg == a_gpo);
  assign wr_ctrl   = wr && (dp_addr_reg == a_ctrl);
  assign wr_load   = wr && (dp_addr_reg == a_load);
  assign wr_status = wr && (dp_addr_reg == a_status);

  // Bus writes are applied after the timer step so they take priority; expiry overrides W1C.
  always_comb begin
    gpo_next     = gpo_reg;
    enable_next  = enable_reg;
    auto_next    = auto_reg;
    irq_en_next  = irq_en_reg;
    expired_next = expired_reg;
    load_next    = load_reg;
    count_next   = count_reg;
    expire       = 1'b0;
    if (enable_reg) begin
      if (count_reg != '0) begin
        count_next = count_reg - count_one;
      end else begin
        expire = 1'b1;
        if (auto_reg) count_next  = load_reg;
        else          enable_next = 1'b0;
      end
    end
    if (wr_gpo) gpo_next = hwdata_i[g_gpo_width-1:0];
    if (wr_ctrl) begin
      enable_next = hwdata_i[0];
      auto_next   = hwdata_i[1];
      irq_en_next = hwdata_i[2];
    end
    if (wr_load) begin
      load_next  = hwdata_i;
      count_next = hwdata_i;
    end
    if (wr_status && hwdata_i[0]) expired_next = 1'b0;
    if (expire) expired_next = 1'b1;
  end

  always_ff @(posedge hclk_i or negedge hreset_n_i) begin
    if (!hreset_n_i) begin
      gpo_reg      <= '0;
      gpi_meta_reg <= '0;
      gpi_sync_reg <= '0;
      enable_reg   <= 1'b0;
      auto_reg     <= 1'b0;
      irq_en_reg   <= 1'b0;
      expired_reg  <= 1'b0;
      load_reg     <= '0;
      count_reg    <= '0;
    end else begin
      gpo_reg      <= gpo_next;
      gpi_meta_reg <= gpi_i;
      gpi_sync_reg <= gpi_meta_reg;
      enable_reg   <= enable_next;
      auto_reg     <= auto_next;
      irq_en_reg   <= irq_en_next;
      expired_reg  <= expired_next;
      load_reg     <= load_next;
      count_reg    <= count_next;
    end
  end

  always_comb begin
    hrdata_o = '0;
    if (dp_valid_reg && !dp_write_reg) begin
      case (dp_addr_reg)
        a_gpo:    hrdata_o[g_gpo_width-1:0] = gpo_reg;
        a_gpi:    hrdata_o[g_gpi_width-1:0] = gpi_sync_reg;
        a_ctrl:   hrdata_o[2:0] = {irq_en_reg, auto_reg, enable_reg};
        a_load:   hrdata_o = load_reg;
        a_count:  hrdata_o = count_reg;
        a_status: hrdata_o[0] = expired_reg;
        default:  hrdata_o = '0;
      endcase
    end
  end

  assign gpo_o = gpo_reg;
  assign irq_o = expired_reg & irq_en_reg;

endmodule
